// File: rtl/pin_router_pkg.sv
// Shared types and helpers for the pin bank router: per-group routing state
// and the flat pad-bus index mapping.
package pin_router_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    PARK   = 2'd2
  } route_state_t;

  localparam int DEF_SEL_W = 2;
  localparam int PARK_SEL  = 2**DEF_SEL_W - 1;

  // Bit position of (port p, group g, bit b) on the flat pad buses.
  function automatic int port_index(input int p, input int g, input int b,
                                    input int num_groups, input int group_w);
    return (p * num_groups + g) * group_w + b;
  endfunction

endpackage

// File: rtl/pin_group_ctrl.sv
// One pin group: break-before-make port switching with a guard interval,
// pad input synchroniser, and out/oe routing to the selected port bank.
module pin_group_ctrl
  import pin_router_pkg::*;
#(
  parameter int GROUP_W      = 8,
  parameter int NUM_PORTS    = 3,
  parameter int SEL_W        = 2,
  parameter int GUARD_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SEL_W-1:0]             sel,
  input  logic [GROUP_W-1:0]           pin_out,
  input  logic [GROUP_W-1:0]           pin_dir,
  output logic [GROUP_W-1:0]           pin_in,
  output logic [NUM_PORTS*GROUP_W-1:0] port_o,
  output logic [NUM_PORTS*GROUP_W-1:0] port_oe,
  input  logic [NUM_PORTS*GROUP_W-1:0] port_i,
  output logic [SEL_W-1:0]             active_sel,
  output logic                         busy
);

  localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W-1:0] PORTS_S  = SEL_W'(NUM_PORTS);

  route_state_t     state_reg, state_next;
  logic [SEL_W-1:0] target_reg, target_next;
  logic [SEL_W-1:0] active_sel_reg, active_sel_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [NUM_PORTS*GROUP_W-1:0] port_sync;
  logic [GROUP_W-1:0]           sync_sel;
  logic [GROUP_W-1:0]           hold_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= DRAIN;
      target_reg     <= sel;
      count_reg      <= CNT_LOAD;
      active_sel_reg <= '0;
    end else begin
      state_reg      <= state_next;
      target_reg     <= target_next;
      count_reg      <= count_next;
      active_sel_reg <= active_sel_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    target_next     = target_reg;
    count_next      = count_reg;
    active_sel_next = active_sel_reg;
    case (state_reg)
      ACTIVE, PARK: begin
        if (sel != active_sel_reg) begin
          state_next  = DRAIN;
          target_next = sel;
          count_next  = CNT_LOAD;
        end
      end
      DRAIN: begin
        // A select change while draining restarts the whole guard.
        if (sel != target_reg) begin
          target_next = sel;
          count_next  = CNT_LOAD;
        end else if (count_reg == '0) begin
          active_sel_next = target_reg;
          state_next      = (target_reg < PORTS_S) ? ACTIVE : PARK;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = DRAIN;
    endcase
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign port_sync = port_i;
    end else begin : g_sync
      logic [NUM_PORTS*GROUP_W-1:0] sync_reg [SYNC_STAGES];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
          sync_reg[0] <= port_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
      end
      assign port_sync = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    sync_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (active_sel_reg == SEL_W'(p)) sync_sel = port_sync[p*GROUP_W +: GROUP_W];
    end
  end

  // Freezes the routed input value whenever the group is not actively connected.
  always_ff @(posedge clock) begin
    if (reset) hold_reg <= '0;
    else if (state_reg == ACTIVE) hold_reg <= sync_sel;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic drive;
      assign drive = (state_reg == ACTIVE) && (active_sel_reg == SEL_W'(gi));
      assign port_oe[gi*GROUP_W +: GROUP_W] = drive ? pin_dir : '0;
      assign port_o[gi*GROUP_W +: GROUP_W]  = drive ? pin_out : '0;
    end
  endgenerate

  assign pin_in     = (pin_dir & pin_out) |
                      (~pin_dir & ((state_reg == ACTIVE) ? sync_sel : hold_reg));
  assign active_sel = active_sel_reg;
  assign busy       = (state_reg == DRAIN);

endmodule

// File: rtl/pin_bank_router.sv
// Routes NUM_GROUPS pin groups to one of NUM_PORTS pad banks each; this level
// only validates parameters and slices the flat buses per group.
module pin_bank_router
  import pin_router_pkg::*;
#(
  parameter int NUM_GROUPS   = 4,
  parameter int GROUP_W      = 8,
  parameter int NUM_PORTS    = 3,
  parameter int SEL_W        = 2,
  parameter int GUARD_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_GROUPS*SEL_W-1:0]             sel,
  input  logic [NUM_GROUPS*GROUP_W-1:0]           pin_out,
  input  logic [NUM_GROUPS*GROUP_W-1:0]           pin_dir,
  output logic [NUM_GROUPS*GROUP_W-1:0]           pin_in,
  output logic [NUM_PORTS*NUM_GROUPS*GROUP_W-1:0] port_o,
  output logic [NUM_PORTS*NUM_GROUPS*GROUP_W-1:0] port_oe,
  input  logic [NUM_PORTS*NUM_GROUPS*GROUP_W-1:0] port_i,
  output logic [NUM_GROUPS*SEL_W-1:0]             active_sel,
  output logic [NUM_GROUPS-1:0]                   busy
);

  generate
    if (2**SEL_W <= NUM_PORTS) begin : g_bad_sel
      $error("pin_bank_router: SEL_W too narrow to leave a park code");
    end
    if (GUARD_CYCLES < 1) begin : g_bad_guard
      $error("pin_bank_router: GUARD_CYCLES must be at least 1");
    end
    if (SYNC_STAGES < 0) begin : g_bad_sync
      $error("pin_bank_router: SYNC_STAGES must not be negative");
    end
  endgenerate

  genvar gi, pi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
      logic [NUM_PORTS*GROUP_W-1:0] grp_o, grp_oe, grp_i;

      pin_group_ctrl #(
        .GROUP_W     (GROUP_W),
        .NUM_PORTS   (NUM_PORTS),
        .SEL_W       (SEL_W),
        .GUARD_CYCLES(GUARD_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .sel       (sel[gi*SEL_W +: SEL_W]),
        .pin_out   (pin_out[gi*GROUP_W +: GROUP_W]),
        .pin_dir   (pin_dir[gi*GROUP_W +: GROUP_W]),
        .pin_in    (pin_in[gi*GROUP_W +: GROUP_W]),
        .port_o    (grp_o),
        .port_oe   (grp_oe),
        .port_i    (grp_i),
        .active_sel(active_sel[gi*SEL_W +: SEL_W]),
        .busy      (busy[gi])
      );

      // Pad buses are port-major; regroup them into this group's per-port view.
      for (pi = 0; pi < NUM_PORTS; pi++) begin : g_port
        localparam int BASE = port_index(pi, gi, 0, NUM_GROUPS, GROUP_W);
        assign port_o[BASE +: GROUP_W]           = grp_o[pi*GROUP_W +: GROUP_W];
        assign port_oe[BASE +: GROUP_W]          = grp_oe[pi*GROUP_W +: GROUP_W];
        assign grp_i[pi*GROUP_W +: GROUP_W]      = port_i[BASE +: GROUP_W];
      end
    end
  endgenerate

endmodule

// File: tb/tb_pin_bank_router.sv
// Scoreboard bench for pin_bank_router: a stability-window routing model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_pin_bank_router;

  localparam int NG   = 4;
  localparam int GW   = 8;
  localparam int NP   = 3;
  localparam int SW   = 2;
  localparam int GC   = 4;
  localparam int SS   = 2;
  localparam int TOT  = NP * NG * GW;
  localparam int MAXE = 4096;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NG*SW-1:0]     sel;
  logic [NG*GW-1:0]     pin_out, pin_dir, pin_in;
  logic [TOT-1:0]       port_o, port_oe, port_i;
  logic [NG*SW-1:0]     active_sel;
  logic [NG-1:0]        busy;

  pin_bank_router #(
    .NUM_GROUPS(NG), .GROUP_W(GW), .NUM_PORTS(NP), .SEL_W(SW),
    .GUARD_CYCLES(GC), .SYNC_STAGES(SS)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .pin_out(pin_out),
    .pin_dir(pin_dir), .pin_in(pin_in), .port_o(port_o), .port_oe(port_oe),
    .port_i(port_i), .active_sel(active_sel), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TOT-1:0]   o;
    logic [TOT-1:0]   oe;
    logic [NG*GW-1:0] pin_in;
    logic [NG*SW-1:0] asel;
    logic [NG-1:0]    busy;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Model: a group is routed to s once sel has read s on GC+1 consecutive
  // edges since the last reset, and stays routed while sel keeps reading s.
  int               edge_n = 0;
  int               rst_edge = 0;
  bit               have_reset = 0;
  logic [NG*SW-1:0] sel_hist [MAXE];
  logic [TOT-1:0]   pi_hist  [MAXE];
  bit               route_valid [NG];
  int               route_sel   [NG];
  int               shown_sel   [NG];
  logic [GW-1:0]    last_shown  [NG];

  task automatic model_edge();
    int e;
    int s;
    bit stable;
    edge_n++;
    e = edge_n;
    if (reset) begin
      have_reset = 1;
      rst_edge   = e;
      sel_hist[e] = sel;
      pi_hist[e]  = '0;
      for (int g = 0; g < NG; g++) begin
        route_valid[g] = 0;
        shown_sel[g]   = 0;
        last_shown[g]  = '0;
      end
    end else if (have_reset) begin
      sel_hist[e] = sel;
      pi_hist[e]  = port_i;
      for (int g = 0; g < NG; g++) begin
        s = int'(sel[g*SW +: SW]);
        if (!(route_valid[g] && s == route_sel[g])) begin
          stable = (e - GC >= rst_edge);
          for (int k = e - GC; k <= e; k++)
            if (stable && int'(sel_hist[k][g*SW +: SW]) != s) stable = 0;
          route_valid[g] = stable;
          if (stable) begin
            route_sel[g] = s;
            shown_sel[g] = s;
          end
        end
      end
    end
  endtask

  task automatic push_expect();
    exp_t x;
    logic [TOT-1:0] synced;
    logic [GW-1:0]  gd, sv;
    logic [SW-1:0]  sa;
    bit act;
    int e;
    e = edge_n;
    synced = (e - SS + 1 >= rst_edge) ? pi_hist[e - SS + 1] : '0;
    x.o = '0;
    x.oe = '0;
    x.pin_in = '0;
    x.asel = '0;
    x.busy = '0;
    x.cyc = e;
    for (int g = 0; g < NG; g++) begin
      gd  = pin_dir[g*GW +: GW];
      act = route_valid[g] && route_sel[g] < NP;
      sv  = act ? synced[(route_sel[g]*NG + g)*GW +: GW] : last_shown[g];
      if (act) begin
        x.oe[(route_sel[g]*NG + g)*GW +: GW] = gd;
        x.o[(route_sel[g]*NG + g)*GW +: GW]  = pin_out[g*GW +: GW];
        last_shown[g] = sv;
      end
      x.pin_in[g*GW +: GW] = (gd & pin_out[g*GW +: GW]) | (~gd & sv);
      sa = shown_sel[g][SW-1:0];
      x.asel[g*SW +: SW] = sa;
      x.busy[g] = !route_valid[g];
    end
    exp_q.push_back(x);
  endtask

  task automatic step(input logic rst_v, input logic [NG*SW-1:0] sel_v, input bit rand_data);
    @(posedge clock);
    model_edge();
    #1;
    reset = rst_v;
    sel   = sel_v;
    if (rand_data) begin
      pin_out = $urandom();
      pin_dir = $urandom();
      port_i  = {$urandom(), $urandom(), $urandom()};
    end
    if (have_reset) push_expect();
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv, input int cyc);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("port_o",     128'(port_o),     128'(x.o),      x.cyc);
        chk("port_oe",    128'(port_oe),    128'(x.oe),     x.cyc);
        chk("pin_in",     128'(pin_in),     128'(x.pin_in), x.cyc);
        chk("active_sel", 128'(active_sel), 128'(x.asel),   x.cyc);
        chk("busy",       128'(busy),       128'(x.busy),   x.cyc);
        $display("cyc=%0d rst=%b sel=%h asel=%h busy=%b oe=%h", x.cyc, reset, sel,
                 active_sel, busy, port_oe);
      end
    end
  end

  initial begin : stimulus
    logic [NG*SW-1:0] s;
    reset   = 1'b1;
    sel     = '0;
    pin_dir = '1;
    pin_out = {NG{8'hA5}};
    port_i  = '0;
    s = '0;
    step(1, s, 0);
    step(1, s, 0);
    // reset release with all groups on port 0
    for (int i = 0; i < 8; i++) step(0, s, 0);
    for (int i = 0; i < 10; i++) step(0, s, 1);
    // group 2 moves to port 1
    s[2*SW +: SW] = 2'd1;
    for (int i = 0; i < 8; i++) step(0, s, 1);
    // group 1 retargets 1 -> 2 while draining
    s[1*SW +: SW] = 2'd1;
    step(0, s, 1);
    s[1*SW +: SW] = 2'd2;
    for (int i = 0; i < 8; i++) step(0, s, 1);
    // group 3 parks
    s[3*SW +: SW] = 2'd3;
    for (int i = 0; i < 12; i++) step(0, s, 1);
    // reset lands mid-drain on group 0
    s[0*SW +: SW] = 2'd2;
    for (int i = 0; i < 3; i++) step(0, s, 1);
    step(1, s, 1);
    for (int i = 0; i < 10; i++) step(0, s, 1);
    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      for (int g = 0; g < NG; g++)
        if ($urandom_range(11) == 0) s[g*SW +: SW] = SW'($urandom_range(3));
      step(($urandom_range(249) == 0) ? 1'b1 : 1'b0, s, 1);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pin_bank_router.md
Name: pin_bank_router

Overview:
- Parametrised successor to the board top-level pin multiplexing.
- Routes NUM_GROUPS groups of Propeller pins, GROUP_W pins each, to one of NUM_PORTS physical port banks per group.
- Per-group select, break-before-make switching with a guard interval, and input synchronisers.
- Sits between the dig core pin buses and the board IOBUF wrappers. Drives out/oe pairs, not inout, so the top level owns every tristate.

Parameters:
- NUM_GROUPS, 4, number of independently routed pin groups.
- GROUP_W, 8, pins per group.
- NUM_PORTS, 3, physical port banks selectable per group.
- SEL_W, 2, select width per group; must satisfy 2**SEL_W > NUM_PORTS so a park code exists.
- GUARD_CYCLES, 16, all-release interval on a select change; must be >= 1.
- SYNC_STAGES, 2, external input synchroniser depth; 0 = bypass.

Ports:
- clock  in  1  core clock (clk_cog domain).
- reset  in  1  synchronous, active-high reset.
- sel  in  NUM_GROUPS*SEL_W  per-group port select, already debounced; group g at [g*SEL_W +: SEL_W].
- pin_out  in  NUM_GROUPS*GROUP_W  core output bus.
- pin_dir  in  NUM_GROUPS*GROUP_W  core direction bus; 1 = output.
- pin_in  out  NUM_GROUPS*GROUP_W  core input bus.
- port_o  out  NUM_PORTS*NUM_GROUPS*GROUP_W  pad output value. Index of (port p, group g, bit b) = (p*NUM_GROUPS+g)*GROUP_W+b.
- port_oe  out  same width  pad output enable.
- port_i  in  same width  pad input value.
- active_sel  out  NUM_GROUPS*SEL_W  port each group currently routes to.
- busy  out  NUM_GROUPS  group is in DRAIN.

Behaviour:
- Per-group FSM states: ACTIVE, DRAIN, PARK. Registers per group: state, target, active_sel, counter (clog2(GUARD_CYCLES) bits).
- Reset (synchronous, takes priority over everything):
  - state=DRAIN, target=sel[g], counter=GUARD_CYCLES-1, active_sel=0.
  - Synchronisers cleared to 0.
  - port_oe=0, port_o=0, busy=1.
- ACTIVE:
  - For p==active_sel: port_oe = pin_dir, port_o = pin_out, combinational, zero latency.
  - All other ports: port_oe=0, port_o=0.
  - If sel[g] != active_sel at a clock edge: enter DRAIN, target=sel[g], counter=GUARD_CYCLES-1.
- DRAIN:
  - All ports of the group have oe=0; busy=1.
  - If sel[g] != target: target=sel[g], counter reloads to GUARD_CYCLES-1 (retarget restarts the guard).
  - Else if counter==0: active_sel=target; next state is ACTIVE if target < NUM_PORTS, else PARK.
  - Else counter decrements.
- PARK:
  - oe=0 on all ports; busy=0.
  - If sel[g] != active_sel: enter DRAIN, same as from ACTIVE.
- Timing guarantee: the old port releases on the first edge after sel changes. The new port drives exactly GUARD_CYCLES cycles later, provided sel is stable.
- Input path, bit i of group g:
  - If pin_dir[i]=1: pin_in[i] = pin_out[i], combinational loopback in every state.
  - Else: pin_in[i] = the synchronised port_i of the active_sel port (SYNC_STAGES cycles latency).
  - In DRAIN and PARK, the synchronised input value for dir=0 bits is frozen at its last value.
- Groups are fully independent; a change on one group never perturbs another.
- Reset mid-DRAIN: the guard restarts from GUARD_CYCLES-1; no port of the group drives until it expires.

Decomposition:
- Package pin_router_pkg:
  - Enum route_state_t {ACTIVE, DRAIN, PARK}.
  - Function port_index(p,g,b).
  - Localparam PARK_SEL = 2**SEL_W-1.
- Sub-module pin_group_ctrl: one group's FSM, guard counter, synchroniser and routing; instanced NUM_GROUPS times in a generate loop.
- The top of pin_bank_router holds only parameter checks and slicing.

Test Plan:
- Reset release: GUARD=4, sel=0, pin_dir=FF, pin_out=A5 → all oe=0 for 4 cycles, then port0 oe=FF, o=A5; busy falls on the same edge.
- Switch group 2 from sel 0 to 1 → port0 g2 oe=0 on the next edge, port1 g2 oe=0 for 4 cycles, then follows pin_dir. Groups 0, 1, 3 unchanged every cycle.
- Retarget: 0→1, then 1→2 at the 2nd DRAIN cycle → port1 never asserts oe; port2 drives 4 cycles after the second change.
- Park: sel=3 with NUM_PORTS=3 → after 4 cycles state PARK, busy=0, all oe=0. dir=0 pin_in bits hold while port_i toggles.
- Input path: dir=0, toggle port_i on the active port → pin_in follows after 2 cycles. dir=1, toggle pin_out → pin_in same cycle, including during DRAIN.
- Reset asserted at DRAIN counter=1 → no oe; the full 4-cycle guard replays after reset release.
